// File: rtl/rtc_bus_pkg.sv
// Shared RTC bus definitions: register addresses, sequencer states and BCD limits.
// Item index order 0..8 is hora/fecha/timer seg-min-hora style; index 9 is the transfer command.
package rtc_bus_pkg;

  localparam logic [7:0] ADDR_SEG_HORA   = 8'h21;
  localparam logic [7:0] ADDR_MIN_HORA   = 8'h22;
  localparam logic [7:0] ADDR_HORA_HORA  = 8'h23;
  localparam logic [7:0] ADDR_DIA_FECHA  = 8'h24;
  localparam logic [7:0] ADDR_MES_FECHA  = 8'h25;
  localparam logic [7:0] ADDR_JAHR_FECHA = 8'h26;
  localparam logic [7:0] ADDR_SEG_TIMER  = 8'h41;
  localparam logic [7:0] ADDR_MIN_TIMER  = 8'h42;
  localparam logic [7:0] ADDR_HORA_TIMER = 8'h43;
  localparam logic [7:0] CMD_TRANSFER    = 8'hF1;

  localparam int N_ITEMS  = 10;
  localparam int ITEM_CMD = 9;

  localparam logic [7:0] LIM_SEG_MIN = 8'h59;
  localparam logic [7:0] LIM_HORA    = 8'h23;
  localparam logic [7:0] LIM_DIA_LO  = 8'h01;
  localparam logic [7:0] LIM_DIA_HI  = 8'h31;
  localparam logic [7:0] LIM_MES_LO  = 8'h01;
  localparam logic [7:0] LIM_MES_HI  = 8'h12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_LO,
    ST_ADDR_HI,
    ST_DATA_LO,
    ST_DATA_HI,
    ST_FINISH
  } rtc_state_e;

  function automatic logic [7:0] item_addr(input logic [3:0] idx);
    case (idx)
      4'd0:    return ADDR_SEG_HORA;
      4'd1:    return ADDR_MIN_HORA;
      4'd2:    return ADDR_HORA_HORA;
      4'd3:    return ADDR_DIA_FECHA;
      4'd4:    return ADDR_MES_FECHA;
      4'd5:    return ADDR_JAHR_FECHA;
      4'd6:    return ADDR_SEG_TIMER;
      4'd7:    return ADDR_MIN_TIMER;
      4'd8:    return ADDR_HORA_TIMER;
      default: return CMD_TRANSFER;
    endcase
  endfunction

  function automatic logic item_in_range(input logic [3:0] idx, input logic [7:0] v);
    logic digits_ok;
    digits_ok = (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    case (idx)
      4'd0, 4'd1, 4'd6, 4'd7: return digits_ok && (v <= LIM_SEG_MIN);
      4'd2, 4'd8:             return digits_ok && (v <= LIM_HORA);
      4'd3:                   return digits_ok && (v >= LIM_DIA_LO) && (v <= LIM_DIA_HI);
      4'd4:                   return digits_ok && (v >= LIM_MES_LO) && (v <= LIM_MES_HI);
      4'd5:                   return digits_ok;
      default:                return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/rtc_write_sequencer_if.sv
// RTC multiplexed parallel bus pins; the sequencer drives them, a monitor or pad ring observes them.
interface rtc_write_sequencer_if;
  import rtc_bus_pkg::*;

  logic [7:0] bus_out;
  logic       bus_oe;
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic       a_d;

  modport master (output bus_out, bus_oe, cs_n, rd_n, wr_n, a_d);
  modport slave  (input  bus_out, bus_oe, cs_n, rd_n, wr_n, a_d);
endinterface

// File: rtl/hour_12_to_24.sv
// Combinational 12 h -> 24 h BCD hour converter; passes the value through in 24 h mode.
module hour_12_to_24
  import rtc_bus_pkg::*;
(
  input  logic [7:0] hour_in,
  input  logic       formato_hora,
  input  logic       am_pm,
  output logic [7:0] hour_out
);

  // PM offsets are plain binary adds chosen so the BCD digits never carry incorrectly.
  always_comb begin
    hour_out = hour_in;
    if (formato_hora) begin
      case (hour_in)
        8'h12:                                     hour_out = am_pm ? 8'h12 : 8'h00;
        8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
        8'h07, 8'h10, 8'h11:                       hour_out = am_pm ? hour_in + 8'h12 : hour_in;
        8'h08, 8'h09:                              hour_out = am_pm ? hour_in + 8'h18 : hour_in;
        default:                                   hour_out = 8'h00;
      endcase
    end
  end

endmodule

// File: rtl/rtc_write_sequencer.sv
// Snapshots edited hora/fecha/timer values and writes them to the RTC, ending with the transfer command.
// Optional macro RTC_BCD_CHECK_EN: skip invalid BCD items and raise a sticky err.
module rtc_write_sequencer
  import rtc_bus_pkg::*;
#(
  parameter int T_PULSE = 10,
  parameter int T_GAP   = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] write_mask,
  input  logic       formato_hora,
  input  logic       am_pm,
  input  logic [7:0] count_seg_hora,
  input  logic [7:0] count_min_hora,
  input  logic [7:0] count_hora_hora,
  input  logic [7:0] count_dia_fecha,
  input  logic [7:0] count_mes_fecha,
  input  logic [7:0] count_jahr_fecha,
  input  logic [7:0] count_seg_timer,
  input  logic [7:0] count_min_timer,
  input  logic [7:0] count_hora_timer,
  rtc_write_sequencer_if.master bus,
  output logic       busy,
  output logic       done,
  output logic       err,
  output rtc_state_e state_dbg
);

  localparam int T_MAX = (T_PULSE > T_GAP) ? T_PULSE : T_GAP;
  localparam int CW    = $clog2(T_MAX) + 1;
  localparam logic [CW-1:0] PULSE_LD = CW'(T_PULSE - 1);
  localparam logic [CW-1:0] GAP_LD_A = CW'(T_GAP - 1);
  localparam logic [CW-1:0] GAP_LD_D = CW'(T_GAP);

  // Handshake: start is sampled only in IDLE with a non-zero mask; busy is high from the
  // next cycle until done, which pulses for one cycle as busy falls.
  rtc_state_e    state;
  logic [CW-1:0] cnt;
  logic [3:0]    ptr_q;
  logic [3:0]    cur_q;
  logic [2:0]    mask_q;
  logic          fmt_q;
  logic          pm_q;
  logic [7:0]    val_q [9];
  logic [7:0]    hora_24;
  logic [7:0]    item_val [N_ITEMS];
  logic          sel_found;
  logic [3:0]    sel_idx;
  logic          sel_skip_err;

  assign state_dbg = state;
  assign bus.rd_n  = 1'b1;

  hour_12_to_24 u_hour (
    .hour_in      (val_q[2]),
    .formato_hora (fmt_q),
    .am_pm        (pm_q),
    .hour_out     (hora_24)
  );

  always_comb begin
    for (int i = 0; i < 9; i++) item_val[i] = val_q[i];
    item_val[2]        = hora_24;
    item_val[ITEM_CMD] = 8'h00;
  end

  // Pick the first enabled item at or after ptr_q; the transfer command is always enabled.
  always_comb begin
    logic grp_on;
    logic ok;
    sel_found    = 1'b0;
    sel_idx      = 4'(ITEM_CMD);
    sel_skip_err = 1'b0;
    for (int i = 0; i < N_ITEMS; i++) begin
      grp_on = (i < 3) ? mask_q[0] : (i < 6) ? mask_q[1] : (i < 9) ? mask_q[2] : 1'b1;
`ifdef RTC_BCD_CHECK_EN
      ok = item_in_range(4'(i), item_val[i]);
`else
      ok = 1'b1;
`endif
      if (!sel_found && (4'(i) >= ptr_q) && grp_on) begin
        if (ok) begin
          sel_found = 1'b1;
          sel_idx   = 4'(i);
        end else begin
          sel_skip_err = 1'b1;
        end
      end
    end
  end

`ifndef RTC_BCD_CHECK_EN
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      ptr_q       <= '0;
      cur_q       <= '0;
      mask_q      <= '0;
      fmt_q       <= 1'b0;
      pm_q        <= 1'b0;
      for (int i = 0; i < 9; i++) val_q[i] <= '0;
      bus.bus_out <= '0;
      bus.bus_oe  <= 1'b0;
      bus.cs_n    <= 1'b1;
      bus.wr_n    <= 1'b1;
      bus.a_d     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef RTC_BCD_CHECK_EN
      err         <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && (write_mask != 3'b000)) begin
            val_q[0] <= count_seg_hora;
            val_q[1] <= count_min_hora;
            val_q[2] <= count_hora_hora;
            val_q[3] <= count_dia_fecha;
            val_q[4] <= count_mes_fecha;
            val_q[5] <= count_jahr_fecha;
            val_q[6] <= count_seg_timer;
            val_q[7] <= count_min_timer;
            val_q[8] <= count_hora_timer;
            mask_q   <= write_mask;
            fmt_q    <= formato_hora;
            pm_q     <= am_pm;
            ptr_q    <= '0;
            busy     <= 1'b1;
            // Enter the bus-released selection cycle that normally ends each item.
            cnt      <= '0;
            state    <= ST_DATA_HI;
`ifdef RTC_BCD_CHECK_EN
            err      <= 1'b0;
`endif
          end
        end
        ST_ADDR_LO: begin
          if (cnt == '0) begin
            bus.wr_n <= 1'b1;
            cnt      <= GAP_LD_A;
            state    <= ST_ADDR_HI;
          end else cnt <= cnt - 1'b1;
        end
        ST_ADDR_HI: begin
          if (cnt == '0) begin
            bus.a_d     <= 1'b1;
            bus.bus_out <= item_val[cur_q];
            bus.wr_n    <= 1'b0;
            cnt         <= PULSE_LD;
            state       <= ST_DATA_LO;
          end else cnt <= cnt - 1'b1;
        end
        ST_DATA_LO: begin
          if (cnt == '0) begin
            bus.wr_n <= 1'b1;
            cnt      <= GAP_LD_D;
            state    <= ST_DATA_HI;
          end else cnt <= cnt - 1'b1;
        end
        ST_DATA_HI: begin
          if (cnt > CW'(1)) begin
            cnt <= cnt - 1'b1;
          end else if (cnt == CW'(1)) begin
            bus.cs_n   <= 1'b1;
            bus.bus_oe <= 1'b0;
            cnt        <= '0;
          end else if (sel_found) begin
            cur_q       <= sel_idx;
            ptr_q       <= sel_idx + 4'd1;
            bus.cs_n    <= 1'b0;
            bus.a_d     <= 1'b0;
            bus.bus_oe  <= 1'b1;
            bus.bus_out <= item_addr(sel_idx);
            bus.wr_n    <= 1'b0;
            cnt         <= PULSE_LD;
            state       <= ST_ADDR_LO;
`ifdef RTC_BCD_CHECK_EN
            if (sel_skip_err) err <= 1'b1;
`endif
          end else begin
            bus.bus_out <= '0;
            bus.a_d     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= ST_FINISH;
          end
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_write_sequencer.sv
// Directed bench: expected {address,data} pairs are queued by stimulus and checked by a bus monitor.
module tb_rtc_write_sequencer;
  import rtc_bus_pkg::*;

  localparam int TP = 10;
  localparam int TG = 5;
  localparam int ITEM_CYC = 2 * TP + 2 * TG + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [2:0] write_mask = 3'b000;
  logic       formato_hora = 1'b0;
  logic       am_pm = 1'b0;
  logic [7:0] count_seg_hora = '0, count_min_hora = '0, count_hora_hora = '0;
  logic [7:0] count_dia_fecha = '0, count_mes_fecha = '0, count_jahr_fecha = '0;
  logic [7:0] count_seg_timer = '0, count_min_timer = '0, count_hora_timer = '0;
  logic       busy, done, err;
  rtc_state_e state_dbg;

  rtc_write_sequencer_if bus_if ();

  rtc_write_sequencer #(.T_PULSE(TP), .T_GAP(TG)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .write_mask       (write_mask),
    .formato_hora     (formato_hora),
    .am_pm            (am_pm),
    .count_seg_hora   (count_seg_hora),
    .count_min_hora   (count_min_hora),
    .count_hora_hora  (count_hora_hora),
    .count_dia_fecha  (count_dia_fecha),
    .count_mes_fecha  (count_mes_fecha),
    .count_jahr_fecha (count_jahr_fecha),
    .count_seg_timer  (count_seg_timer),
    .count_min_timer  (count_min_timer),
    .count_hora_timer (count_hora_timer),
    .bus              (bus_if.master),
    .busy             (busy),
    .done             (done),
    .err              (err),
    .state_dbg        (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];
  int          done_cnt = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor
  logic       prev_wr = 1'b1;
  int         low_cnt = 0;
  logic [7:0] cur_addr = '0;

  always @(negedge clk) begin
    if (!reset) begin
      prev_wr = 1'b1;
      low_cnt = 0;
    end else begin
      if (bus_if.wr_n == 1'b0 && prev_wr == 1'b1) begin
        check("cs_during_write", {15'd0, bus_if.cs_n}, 16'd0);
        if (bus_if.a_d == 1'b0) cur_addr = bus_if.bus_out;
        else if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write: got %h%h expected none", cur_addr, bus_if.bus_out);
        end else check("bus_write", {cur_addr, bus_if.bus_out}, exp_q.pop_front());
      end
      if (bus_if.wr_n == 1'b0) low_cnt++;
      else if (prev_wr == 1'b0) begin
        check("wr_pulse_width", 16'(low_cnt), 16'(TP));
        low_cnt = 0;
      end
      if (done) begin
        done_cnt++;
        check("done_busy_low", {15'd0, busy}, 16'd0);
        check("done_queue_empty", 16'(exp_q.size()), 16'd0);
      end
      prev_wr = bus_if.wr_n;
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_vals(input logic [7:0] s, m, h, d, mo, j, ts, tm, th);
    count_seg_hora = s;   count_min_hora = m;   count_hora_hora = h;
    count_dia_fecha = d;  count_mes_fecha = mo; count_jahr_fecha = j;
    count_seg_timer = ts; count_min_timer = tm; count_hora_timer = th;
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic pulse_start(input logic [2:0] mask, input logic fmt, input logic pm);
    @(negedge clk);
    write_mask = mask;
    formato_hora = fmt;
    am_pm = pm;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!done && cycles < 2000) begin
      @(negedge clk);
      cycles++;
    end
    check("done_seen", {15'd0, done}, 16'd1);
    tick(2);
  endtask

  logic [7:0] hr_in  [5] = '{8'h12, 8'h12, 8'h07, 8'h11, 8'h15};
  logic       hr_pm  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [7:0] hr_exp [5] = '{8'h00, 8'h12, 8'h19, 8'h23, 8'h00};

  initial begin
    int c;
    int dc;
    int k;

    tick(3);
    #1;
    check("rst_cs_n", {15'd0, bus_if.cs_n}, 16'd1);
    check("rst_wr_n", {15'd0, bus_if.wr_n}, 16'd1);
    check("rst_rd_n", {15'd0, bus_if.rd_n}, 16'd1);
    check("rst_bus_oe", {15'd0, bus_if.bus_oe}, 16'd0);
    check("rst_bus_out", {8'd0, bus_if.bus_out}, 16'd0);
    check("rst_a_d", {15'd0, bus_if.a_d}, 16'd0);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_done", {15'd0, done}, 16'd0);
    check("rst_err", {15'd0, err}, 16'd0);
    check("rst_state", {13'd0, state_dbg}, {13'd0, ST_IDLE});
    @(negedge clk);
    reset = 1'b1;
    tick(2);

    // full write, 24 h mode
    set_vals(8'h45, 8'h30, 8'h14, 8'h07, 8'h04, 8'h16, 8'h10, 8'h05, 8'h01);
    push(8'h21, 8'h45); push(8'h22, 8'h30); push(8'h23, 8'h14);
    push(8'h24, 8'h07); push(8'h25, 8'h04); push(8'h26, 8'h16);
    push(8'h41, 8'h10); push(8'h42, 8'h05); push(8'h43, 8'h01);
    push(8'hF1, 8'h00);
    pulse_start(3'b111, 1'b0, 1'b0);
    check("busy_rise", {15'd0, busy}, 16'd1);
    wait_done(c);
    check("full_latency", 16'(c), 16'(10 * ITEM_CYC + 1));

    // hour conversion, hora group only
    for (int i = 0; i < 5; i++) begin
      count_hora_hora = hr_in[i];
      push(8'h21, 8'h45); push(8'h22, 8'h30); push(8'h23, hr_exp[i]); push(8'hF1, 8'h00);
      pulse_start(3'b001, 1'b1, hr_pm[i]);
      wait_done(c);
      check("hour_latency", 16'(c), 16'(4 * ITEM_CYC + 1));
    end

    // timer group only, with a start while busy that must be ignored
    set_vals(8'h45, 8'h30, 8'h14, 8'h07, 8'h04, 8'h16, 8'h10, 8'h05, 8'h01);
    push(8'h41, 8'h10); push(8'h42, 8'h05); push(8'h43, 8'h01); push(8'hF1, 8'h00);
    dc = done_cnt;
    pulse_start(3'b100, 1'b0, 1'b0);
    tick(40);
    pulse_start(3'b111, 1'b0, 1'b0);
    wait_done(c);
    tick(50);
    check("no_restart_busy", {15'd0, busy}, 16'd0);
    check("no_restart_done_cnt", 16'(done_cnt - dc), 16'd1);

    // empty mask is ignored
    pulse_start(3'b000, 1'b0, 1'b0);
    tick(3);
    check("mask0_busy", {15'd0, busy}, 16'd0);
    check("mask0_state", {13'd0, state_dbg}, {13'd0, ST_IDLE});

    // snapshot: minute changes after start
    set_vals(8'h45, 8'h30, 8'h14, 8'h07, 8'h04, 8'h16, 8'h10, 8'h05, 8'h01);
    push(8'h21, 8'h45); push(8'h22, 8'h30); push(8'h23, 8'h14); push(8'hF1, 8'h00);
    pulse_start(3'b001, 1'b0, 1'b0);
    k = 0;
    while (bus_if.wr_n != 1'b0 && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("snap_addr_lo_seen", {15'd0, bus_if.wr_n}, 16'd0);
    count_min_hora = 8'h31;
    wait_done(c);

`ifdef RTC_BCD_CHECK_EN
    set_vals(8'h45, 8'h30, 8'h14, 8'h3A, 8'h04, 8'h16, 8'h10, 8'h05, 8'h01);
    push(8'h25, 8'h04); push(8'h26, 8'h16); push(8'hF1, 8'h00);
    pulse_start(3'b010, 1'b0, 1'b0);
    wait_done(c);
    check("bcd_err_set", {15'd0, err}, 16'd1);
    set_vals(8'h45, 8'h30, 8'h14, 8'h07, 8'h04, 8'h16, 8'h10, 8'h05, 8'h01);
    push(8'h21, 8'h45); push(8'h22, 8'h30); push(8'h23, 8'h14); push(8'hF1, 8'h00);
    pulse_start(3'b001, 1'b0, 1'b0);
    tick(1);
    check("bcd_err_cleared", {15'd0, err}, 16'd0);
    wait_done(c);
`else
    set_vals(8'h45, 8'h30, 8'h14, 8'h3A, 8'h04, 8'h16, 8'h10, 8'h05, 8'h01);
    push(8'h24, 8'h3A); push(8'h25, 8'h04); push(8'h26, 8'h16); push(8'hF1, 8'h00);
    pulse_start(3'b010, 1'b0, 1'b0);
    wait_done(c);
    check("nocheck_err", {15'd0, err}, 16'd0);
`endif

    // reset in the middle of the first DATA_LO
    set_vals(8'h45, 8'h30, 8'h14, 8'h07, 8'h04, 8'h16, 8'h10, 8'h05, 8'h01);
    push(8'h21, 8'h45);
    pulse_start(3'b111, 1'b0, 1'b0);
    k = 0;
    while (!(bus_if.a_d == 1'b1 && bus_if.wr_n == 1'b0) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("rst_test_data_lo_seen", {15'd0, bus_if.a_d}, 16'd1);
    tick(3);
    dc = done_cnt;
    #2 reset = 1'b0;
    #1;
    check("midrst_cs_n", {15'd0, bus_if.cs_n}, 16'd1);
    check("midrst_wr_n", {15'd0, bus_if.wr_n}, 16'd1);
    check("midrst_bus_oe", {15'd0, bus_if.bus_oe}, 16'd0);
    check("midrst_busy", {15'd0, busy}, 16'd0);
    tick(3);
    reset = 1'b1;
    tick(40);
    check("midrst_no_done", 16'(done_cnt - dc), 16'd0);
    check("midrst_idle_busy", {15'd0, busy}, 16'd0);
    check("midrst_queue_empty", 16'(exp_q.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rtc_write_sequencer.md
Name: rtc_write_sequencer

Overview:
- Write-side counterpart of the VGA register memory. On a start pulse it snapshots the edited hora/fecha/timer values from the counters.
- It converts the hour back from 12 h to 24 h format when needed. It then writes each value to the RTC over the multiplexed parallel bus (address phase, then data phase), and ends with the RTC transfer command.
- It sits between the count/edit logic and the RTC bus pins, alongside the PicoBlaze read path.

Parameters:
- T_PULSE, 10, clk cycles wr_n is held low in each phase (min 1).
- T_GAP, 5, clk cycles wr_n is held high after each phase (min 1).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a write sequence
- write_mask  in  3  group enable: [0] hora, [1] fecha, [2] timer
- formato_hora  in  1  1 = hour input is 12 h BCD, 0 = 24 h BCD
- am_pm  in  1  0 = AM, 1 = PM (used only in 12 h mode)
- count_seg_hora, count_min_hora, count_hora_hora  in  8 each  BCD time values
- count_dia_fecha, count_mes_fecha, count_jahr_fecha  in  8 each  BCD date values
- count_seg_timer, count_min_timer, count_hora_timer  in  8 each  BCD timer values
- bus_out  out  8  address/data driven to the RTC
- bus_oe  out  1  tristate enable for bus_out
- cs_n, rd_n, wr_n  out  1 each  RTC strobes, active low
- a_d  out  1  0 = address phase, 1 = data phase
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse when the sequence completes
- err  out  1  sticky BCD error (only with the feature enabled)

Behaviour:
- Reset (async, reset = 0): state IDLE; bus_out 0, bus_oe 0, cs_n 1, rd_n 1, wr_n 1, a_d 0, busy 0, done 0, err 0. rd_n is constant 1.
- Reset asserted mid-sequence: bus strobes release immediately; the partial write is abandoned with no done pulse.
- Start acceptance:
  - In IDLE, start = 1 with write_mask != 0 latches all nine values, formato_hora, am_pm and write_mask.
  - busy rises on the next cycle.
  - start while busy is ignored; start with write_mask = 0 is ignored.
- Register list, in order, skipping disabled groups:
  - hora: seg 0x21, min 0x22, hora 0x23
  - fecha: dia 0x24, mes 0x25, jahr 0x26
  - timer: seg 0x41, min 0x42, hora 0x43
  - last item: transfer command, address 0xF1, data 0x00.
- FSM: IDLE -> ADDR_LO -> ADDR_HI -> DATA_LO -> DATA_HI -> (next item ? ADDR_LO : FINISH) -> IDLE.
  - ADDR_LO: cs_n 0, a_d 0, bus_oe 1, bus_out = address, wr_n 0, for T_PULSE cycles.
  - ADDR_HI: wr_n 1, bus still driven, for T_GAP cycles.
  - DATA_LO: a_d 1, bus_out = data, wr_n 0, for T_PULSE cycles.
  - DATA_HI: wr_n 1 for T_GAP cycles, then cs_n 1 and bus_oe 0 for one cycle before the next item.
  - FINISH: done = 1 for one cycle, busy falls the same cycle.
- Per-item duration: 2·T_PULSE + 2·T_GAP + 1 cycles. bus_out and a_d change only while wr_n = 1.
- Cycle counter: width $clog2(max(T_PULSE, T_GAP)) + 1; reloads on every state entry.
- Hour conversion, applied to the latched hora_hora only (timer hour is never converted):
  - formato_hora = 0: the value passes through unchanged.
  - formato_hora = 1, AM: 0x12 -> 0x00; 0x01..0x11 unchanged.
  - formato_hora = 1, PM: 0x12 -> 0x12; 0x01..0x09 -> 0x13..0x21; 0x10 -> 0x22; 0x11 -> 0x23.
  - Any other value in 12 h mode -> 0x00.
- Inputs changing during busy have no effect, because all values are snapshotted at start.

Optional Feature:
- Macro RTC_BCD_CHECK_EN.
- Defined: each data byte is checked before its ADDR_LO. A byte is invalid if either nibble is > 9, or it exceeds its range (seg/min 0x59; hora 0x23; dia 0x01..0x31; mes 0x01..0x12; timer hora 0x23).
  - An invalid item is skipped entirely, with no bus activity.
  - err is set and stays set until the next accepted start, which clears it.
  - The transfer command is still issued.
- Undefined: no check; data is written as given; err is tied to 0.

Decomposition:
- Package rtc_bus_pkg: the nine RTC address constants, CMD_TRANSFER = 0xF1, the FSM state enum, and the BCD limit constants.
- Sub-module hour_12_to_24: combinational 12 h to 24 h BCD converter. Natural to separate and to unit-test on its own.

Test Plan:
- Reset: hold reset = 0 mid-DATA_LO -> cs_n = 1, wr_n = 1, bus_oe = 0 and busy = 0 within the same cycle; no done pulse.
- Full write: mask 3'b111, values 0x45/0x30/0x14/0x07/0x04/0x16/0x10/0x05/0x01, formato_hora = 0.
  - Expect 10 transactions, addresses 0x21..0x26, 0x41..0x43, 0xF1, with the matching data and last data 0x00.
  - Expect done exactly 10·(2·10 + 2·5 + 1) + 1 cycles after busy rises.
- Hour conversion: mask 3'b001, formato_hora = 1.
  - 0x12 AM -> 0x00; 0x12 PM -> 0x12; 0x07 PM -> 0x19; 0x11 PM -> 0x23; 0x15 AM -> 0x00.
- Masking and ignore rules: mask 3'b100 -> only 0x41, 0x42, 0x43, 0xF1 appear; start while busy -> no restart; mask 0 -> busy stays 0.
- Snapshot: change count_min_hora from 0x30 to 0x31 during ADDR_LO of seg -> written data is 0x30.
- RTC_BCD_CHECK_EN defined: count_dia_fecha = 0x3A -> address 0x24 absent from the bus, err = 1; next accepted start clears err.
